vec3_length_arbiter: RTL and testbench

- Shares one pipelined vec3Length unit among N_REQ ray-march lanes.
- Arbitration is round-robin, one issue per cycle.
- Each issue is tagged with its requester ID, and every result is routed back to the lane that asked for it.
- A credit-checked result FIFO means the length unit, which has no backpressure, can never overflow a stalled consumer.

---
 rtl/vec3_length_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_vec3_length_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec3_length_arbiter.sv
// vec3_length_arbiter: shares one pipelined, in-order, fixed-latency vec3 length unit
// among N_REQ lanes. Round-robin issue, one per cycle; each issue is tagged with its lane ID
// and the result is routed back through a credit-checked result FIFO, so the length unit
// (which has no backpressure) can never overrun a stalled consumer.
// Optional per-lane grant / stall statistics are enabled by defining VEC3_ARB_STATS_EN.
module vec3_length_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 24,
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned RESP_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*3*DATA_WIDTH-1:0] req_vec,
    output logic [N_REQ-1:0]              resp_valid,
    input  logic [N_REQ-1:0]              resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_length,
    output logic [3*DATA_WIDTH-1:0]       len_vec,
    output logic                          len_valid_in,
    input  logic [DATA_WIDTH-1:0]         len_length,
    input  logic                          len_valid_out,
    output logic                          busy,
    output logic                          err_orphan
`ifdef VEC3_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]           stat_grants,
    output logic [15:0]                   stat_stall
`endif
);

    localparam int unsigned VecW = 3 * DATA_WIDTH;
    localparam int unsigned TagW = $clog2(N_REQ);
    localparam int unsigned PtrW = $clog2(RESP_DEPTH);
    localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);
    localparam int unsigned ResW = TagW + DATA_WIDTH;
    localparam logic [CntW-1:0] FullCredits = CntW'(RESP_DEPTH);

    // Elaboration-time parameter sanity; FRAC_BITS is only meaningful below DATA_WIDTH.
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("N_REQ must be in 2..8");
    end
    if (RESP_DEPTH < 2 || (RESP_DEPTH & (RESP_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RESP_DEPTH must be a power of two >= 2");
    end
    if (FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
        $error("FRAC_BITS must be smaller than DATA_WIDTH");
    end

    // Arbitration and credit state
    logic [TagW-1:0]  rr_q, rr_d;
    logic [CntW-1:0]  credit_q, credit_d;
    logic [N_REQ-1:0] grant;
    logic [TagW-1:0]  grant_idx;
    logic             grant_found;
    logic [TagW:0]    cand;
    logic [TagW:0]    rr_nxt;
    logic             has_credit;
    logic             accept;
    logic [VecW-1:0]  issue_vec;

    // Issue register toward the length unit
    logic [VecW-1:0]  len_vec_q, len_vec_d;
    logic             len_valid_q, len_valid_d;

    // Tag FIFO: lane IDs of ops inside the length unit
    logic [TagW-1:0]  tag_mem [RESP_DEPTH];
    logic [PtrW-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CntW-1:0]  tag_cnt_q, tag_cnt_d;
    logic             tag_pop;

    // Result FIFO: {tag, length} waiting for the owning lane
    logic [ResW-1:0]  res_mem [RESP_DEPTH];
    logic [PtrW-1:0]  res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CntW-1:0]  res_cnt_q, res_cnt_d;
    logic             res_push, res_pop, res_nonempty;
    logic [ResW-1:0]  res_head;

    logic             err_q, err_d;

    // Round-robin search from rr_q upward with wrap-around
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + (TagW + 1)'(i);
            if (cand >= (TagW + 1)'(N_REQ)) begin
                cand = cand - (TagW + 1)'(N_REQ);
            end
            if (!grant_found && req_valid[cand[TagW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[TagW-1:0];
            end
        end
        grant[grant_idx] = grant_found;
    end

    // Handshake decode, operand select and response head decode
    always_comb begin
        has_credit = (credit_q != '0);
        req_ready  = (rst || !has_credit) ? '0 : grant;
        accept     = grant_found && has_credit && !rst;
        issue_vec  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                issue_vec = req_vec[i*VecW +: VecW];
            end
        end
        tag_pop      = len_valid_out && (tag_cnt_q != '0);
        res_push     = tag_pop;
        res_nonempty = (res_cnt_q != '0);
        res_head     = res_mem[res_rd_q];
        resp_valid   = '0;
        if (res_nonempty) begin
            resp_valid[res_head[ResW-1:DATA_WIDTH]] = 1'b1;
        end
        // Zeroed when empty so an unwritten FIFO slot never reaches the lanes
        resp_length = res_nonempty ? res_head[DATA_WIDTH-1:0] : '0;
        res_pop     = |(resp_valid & resp_ready);
    end

    // Next-state: pointer, credits, issue register, FIFO pointers/counts, orphan flag
    always_comb begin
        rr_nxt = {1'b0, grant_idx} + (TagW + 1)'(1);
        if (rr_nxt == (TagW + 1)'(N_REQ)) begin
            rr_nxt = '0;
        end
        rr_d        = accept ? rr_nxt[TagW-1:0] : rr_q;
        len_valid_d = accept;
        len_vec_d   = accept ? issue_vec : len_vec_q;

        credit_d = credit_q;
        unique case ({accept, res_pop})
            2'b10:   credit_d = credit_q - CntW'(1);
            2'b01:   credit_d = credit_q + CntW'(1);
            default: credit_d = credit_q;
        endcase

        tag_wr_d  = accept  ? tag_wr_q + PtrW'(1) : tag_wr_q;
        tag_rd_d  = tag_pop ? tag_rd_q + PtrW'(1) : tag_rd_q;
        tag_cnt_d = tag_cnt_q;
        unique case ({accept, tag_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + CntW'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - CntW'(1);
            default: tag_cnt_d = tag_cnt_q;
        endcase

        res_wr_d  = res_push ? res_wr_q + PtrW'(1) : res_wr_q;
        res_rd_d  = res_pop  ? res_rd_q + PtrW'(1) : res_rd_q;
        res_cnt_d = res_cnt_q;
        unique case ({res_push, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + CntW'(1);
            2'b01:   res_cnt_d = res_cnt_q - CntW'(1);
            default: res_cnt_d = res_cnt_q;
        endcase

        // A result with no tag outstanding is dropped and flagged until reset
        err_d = err_q | (len_valid_out && (tag_cnt_q == '0));
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            credit_q    <= FullCredits;
            len_vec_q   <= '0;
            len_valid_q <= 1'b0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            tag_cnt_q   <= '0;
            res_wr_q    <= '0;
            res_rd_q    <= '0;
            res_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            credit_q    <= credit_d;
            len_vec_q   <= len_vec_d;
            len_valid_q <= len_valid_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            tag_cnt_q   <= tag_cnt_d;
            res_wr_q    <= res_wr_d;
            res_rd_q    <= res_rd_d;
            res_cnt_q   <= res_cnt_d;
            err_q       <= err_d;
        end
    end

    // FIFO storage; contents are don't-care while the matching count is zero
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr_q] <= grant_idx;
        end
        if (res_push) begin
            res_mem[res_wr_q] <= {tag_mem[tag_rd_q], len_length};
        end
    end

    // Registered-state outputs
    always_comb begin
        len_vec      = len_vec_q;
        len_valid_in = len_valid_q;
        busy         = (credit_q != FullCredits);
        err_orphan   = err_q;
    end

`ifdef VEC3_ARB_STATS_EN
    logic [15:0] grant_cnt_q [N_REQ];
    logic [15:0] stall_cnt_q;
    logic        stall;

    // Saturating per-lane grant counters and credit-stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept && grant_idx == TagW'(i) && grant_cnt_q[i] != 16'hFFFF) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // Flatten counters onto the stat ports
    always_comb begin
        stall       = (|req_valid) && !has_credit;
        stat_grants = '0;
        for (int i = 0; i < N_REQ; i++) begin
            stat_grants[i*16 +: 16] = grant_cnt_q[i];
        end
        stat_stall = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_vec3_length_arbiter.sv
// Directed bench for vec3_length_arbiter with a 5-stage stub length unit.
module tb_vec3_length_arbiter;

    localparam int DW    = 32;
    localparam int NR    = 4;
    localparam int DEPTH = 8;
    localparam int VW    = 3 * DW;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*VW-1:0]  req_vec;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    logic [DW-1:0]     resp_length;
    logic [VW-1:0]     len_vec;
    logic              len_valid_in;
    logic [DW-1:0]     len_length;
    logic              len_valid_out;
    logic              busy;
    logic              err_orphan;
    logic              inject;

    vec3_length_arbiter #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (24),
        .N_REQ      (NR),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_vec       (req_vec),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_length   (resp_length),
        .len_vec       (len_vec),
        .len_valid_in  (len_valid_in),
        .len_length    (len_length),
        .len_valid_out (len_valid_out),
        .busy          (busy),
        .err_orphan    (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub length unit: 5 register stages, shares the arbiter reset
    logic [DW-1:0] pipe_d [5];
    logic          pipe_v [5];

    function automatic logic [DW-1:0] len_fn(input logic [VW-1:0] v);
        real x, y, z;
        x = $itor(v[95:64]);
        y = $itor(v[63:32]);
        z = $itor(v[31:0]);
        return 32'($rtoi($sqrt(x * x + y * y + z * z)));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0] <= len_valid_in;
            pipe_d[0] <= len_fn(len_vec);
            for (int i = 1; i < 5; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign len_valid_out = pipe_v[4] | inject;
    assign len_length    = pipe_d[4];

    // Operand table with hand-computed lengths (Q8.24)
    logic [VW-1:0] vtab [5];
    logic [DW-1:0] ltab [5];
    int            ttab [5];
    int            lane_k [NR];

    typedef struct {
        int            lane;
        logic [DW-1:0] val;
        int            tol;
    } exp_t;

    exp_t sb_q [$];
    int   grant_log [$];
    int   n_cmp, n_bad, n_acc, n_hs, n_both, out_n;

    task automatic check_val(input string tag, input logic [VW-1:0] got,
                             input logic [VW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_lane(input int lane, input int k);
        lane_k[lane] = k;
        req_vec[lane*VW +: VW] = vtab[k];
    endtask

    // One clock: observe handshakes just before the edge, then land on the next negedge
    task automatic cyc();
        logic [NR-1:0] acc, hs;
        int            lane, d;
        exp_t          e;
        #3;
        acc = req_valid & req_ready;
        hs  = resp_valid & resp_ready;
        if (rst) begin
            sb_q.delete();
            out_n = 0;
        end else begin
            check_val("ready_onehot", VW'($countones(req_ready) <= 1), 1);
            if (out_n >= DEPTH) check_val("no_credit_ready", req_ready, 0);
            if (hs != 0) begin
                lane = first_idx(hs);
                n_hs++;
                out_n--;
                if (sb_q.size() == 0) begin
                    check_val("resp_spurious", hs, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("resp_lane", lane, e.lane);
                    d = (resp_length > e.val) ? int'(resp_length - e.val)
                                              : int'(e.val - resp_length);
                    check_val("resp_len", (d <= e.tol) ? e.val : resp_length, e.val);
                end
            end
            if (acc != 0) begin
                lane = first_idx(acc);
                grant_log.push_back(lane);
                n_acc++;
                out_n++;
                sb_q.push_back('{lane, ltab[lane_k[lane]], ttab[lane_k[lane]]});
            end
            if (acc != 0 && hs != 0) n_both++;
        end
        @(negedge clk);
        check_val("busy", busy, out_n != 0);
    endtask

    task automatic chk_reset_outputs();
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_resp_valid", resp_valid, 0);
        check_val("rst_len_valid_in", len_valid_in, 0);
        check_val("rst_len_vec", len_vec, 0);
        check_val("rst_resp_length", resp_length, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err_orphan", err_orphan, 0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        inject     = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, h0;
        vtab[0] = {32'h03000000, 32'h04000000, 32'h00000000}; ltab[0] = 32'h05000000; ttab[0] = 0;
        vtab[1] = {32'h01000000, 32'h02000000, 32'h02000000}; ltab[1] = 32'h03000000; ttab[1] = 0;
        vtab[2] = {32'h02000000, 32'h03000000, 32'h06000000}; ltab[2] = 32'h07000000; ttab[2] = 0;
        vtab[3] = {32'h01000000, 32'h01000000, 32'h01000000}; ltab[3] = 32'h01BB67AE; ttab[3] = 2;
        vtab[4] = {32'h01000000, 32'h04000000, 32'h08000000}; ltab[4] = 32'h09000000; ttab[4] = 0;
        n_cmp = 0; n_bad = 0; n_acc = 0; n_hs = 0; n_both = 0; out_n = 0;
        req_vec = '0;
        for (int i = 0; i < NR; i++) set_lane(i, 0);

        // Reset state
        do_reset();
        rst = 1'b1;
        chk_reset_outputs();
        rst = 1'b0;

        // Single request on lane 1: result visible 7 cycles after the accept cycle
        set_lane(1, 0);
        req_valid  = 4'b0010;
        resp_ready = 4'b1111;
        #1;
        check_val("t1_ready", req_ready, 4'b0010);
        cyc();
        req_valid = '0;
        check_val("t1_len_valid_in", len_valid_in, 1);
        check_val("t1_len_vec", len_vec, vtab[0]);
        for (int c = 2; c <= 7; c++) begin
            cyc();
            if (c == 6) check_val("t1_resp_early", resp_valid, 4'b0000);
            if (c == 7) begin
                check_val("t1_resp_valid", resp_valid, 4'b0010);
                check_val("t1_resp_length", resp_length, 32'h05000000);
            end
        end
        for (int c = 0; c < 5; c++) cyc();
        check_val("t1_drained", sb_q.size(), 0);

        // Round robin with all lanes requesting continuously
        do_reset();
        grant_log.delete();
        for (int i = 0; i < NR; i++) set_lane(i, i);
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        a0 = n_acc;
        for (int c = 0; c < 16; c++) cyc();
        req_valid = '0;
        check_val("t2_accepts", n_acc - a0, 16);
        for (int i = 0; i < 8; i++) check_val("t2_grant_order", grant_log[i], i % NR);
        for (int c = 0; c < 12; c++) cyc();
        check_val("t2_drained", sb_q.size(), 0);

        // Backpressure: all results stalled, then lane 0 drains
        do_reset();
        set_lane(0, 1);
        req_valid  = 4'b0001;
        resp_ready = 4'b0000;
        a0 = n_acc;
        for (int c = 0; c < 30; c++) cyc();
        check_val("t3_accepts", n_acc - a0, DEPTH);
        check_val("t3_ready_low", req_ready, 0);
        check_val("t3_busy", busy, 1);
        resp_ready = 4'b0001;
        a0 = n_acc;
        h0 = n_hs;
        for (int c = 0; c < 40; c++) cyc();
        check_val("t3_drain", (n_hs - h0) >= 8, 1);
        check_val("t3_resume", (n_acc - a0) >= 8, 1);
        req_valid = '0;
        for (int c = 0; c < 20; c++) cyc();
        check_val("t3_drained", sb_q.size(), 0);

        // Directed (1,2,2) and (1,1,1), then random overlap of issue and handshake
        do_reset();
        resp_ready = 4'b1111;
        set_lane(2, 1);
        set_lane(3, 3);
        req_valid = 4'b1100;
        cyc();
        req_valid = 4'b1000;
        cyc();
        req_valid = '0;
        for (int c = 0; c < 10; c++) cyc();
        check_val("t4_directed_done", sb_q.size(), 0);
        n_both = 0;
        for (int c = 0; c < 100; c++) begin
            for (int l = 0; l < NR; l++) set_lane(l, $urandom_range(0, 4));
            req_valid  = 4'($urandom_range(0, 15));
            resp_ready = 4'($urandom_range(0, 15));
            cyc();
        end
        req_valid  = '0;
        resp_ready = 4'b1111;
        for (int c = 0; c < 30; c++) cyc();
        check_val("t4_overlap_seen", n_both > 0, 1);
        check_val("t4_drained", sb_q.size(), 0);

        // Orphan result: flagged, dropped, sticky until reset
        do_reset();
        inject = 1'b1;
        cyc();
        inject = 1'b0;
        check_val("t5_orphan_set", err_orphan, 1);
        check_val("t5_no_resp", resp_valid, 0);
        for (int c = 0; c < 10; c++) cyc();
        check_val("t5_orphan_sticky", err_orphan, 1);
        check_val("t5_no_resp_later", resp_valid, 0);
        do_reset();
        check_val("t5_orphan_cleared", err_orphan, 0);

        // Reset with five ops in flight, then a normal request
        for (int i = 0; i < NR; i++) set_lane(i, 4);
        req_valid  = 4'b1111;
        resp_ready = 4'b0000;
        a0 = n_acc;
        for (int c = 0; c < 5; c++) cyc();
        req_valid = '0;
        check_val("t6_in_flight", n_acc - a0, 5);
        rst = 1'b1;
        cyc();
        chk_reset_outputs();
        rst = 1'b0;
        set_lane(2, 2);
        req_valid  = 4'b0100;
        resp_ready = 4'b1111;
        h0 = n_hs;
        cyc();
        req_valid = '0;
        for (int c = 0; c < 12; c++) cyc();
        check_val("t6_served", n_hs - h0, 1);
        check_val("t6_drained", sb_q.size(), 0);
        check_val("t6_no_orphan", err_orphan, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
